// File: rtl/fifo_wr_sched_if.sv
// Producer-side and FIFO-side signals of the FIFO write scheduler, bundled.
// master = scheduler, slave = producers/FIFO/consumer environment.
interface fifo_wr_sched_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] din;
  logic [N_REQ-1:0]    ack;
  logic                rd_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_w_en;
  logic [DW-1:0]       fifo_data_in;
  logic                pop_vld;
  logic [GW-1:0]       gnt_id;

  modport master (
    input  req, din, rd_req, fifo_full, fifo_empty,
    output ack, fifo_w_en, fifo_data_in, pop_vld, gnt_id
  );

  modport slave (
    output req, din, rd_req, fifo_full, fifo_empty,
    input  ack, fifo_w_en, fifo_data_in, pop_vld, gnt_id
  );
endinterface

// File: rtl/fifo_wr_sched.sv
// Round-robin scheduler for a shared sync FIFO write port with burst cap and
// interleaved read windows; the FIFO drains on every cycle it is not written.
module fifo_wr_sched #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int RD_SLOTS  = 2
) (
  input  logic           clk,
  input  logic           rst,
  fifo_wr_sched_if.master bus
);
  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_id_q, gnt_id_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  logic [3:0]    slot_cnt_q, slot_cnt_d;
  logic          rd_turn_q, rd_turn_d;
  logic          pop_vld_q, pop_vld_d;

  logic          push;
  logic          wr_exit;
  logic          rd_exit;
  logic          rr_found;
  logic [GW-1:0] rr_idx;
  logic [GW-1:0] rr_next;
  logic [N_REQ-1:0] ack_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_id_q    <= GW'(N_REQ - 1);
      burst_cnt_q <= '0;
      slot_cnt_q  <= '0;
      rd_turn_q   <= 1'b0;
      pop_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      burst_cnt_q <= burst_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      rd_turn_q   <= rd_turn_d;
      pop_vld_q   <= pop_vld_d;
    end
  end

  // Cyclic search starting just after the last granted producer.
  always_comb begin
    rr_next  = gnt_id_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = GW'((int'(gnt_id_q) + k) % N_REQ);
      if (!rr_found && bus.req[rr_idx]) begin
        rr_found = 1'b1;
        rr_next  = rr_idx;
      end
    end
  end

  assign push    = (state_q == WRITE) && bus.req[gnt_id_q] && !bus.fifo_full;
  assign wr_exit = (push && (burst_cnt_q == 4'(MAX_BURST - 1))) ||
                   !bus.req[gnt_id_q] || bus.fifo_full;
  assign rd_exit = (slot_cnt_q == 4'(RD_SLOTS - 1)) || bus.fifo_empty || !bus.rd_req;

  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    burst_cnt_d = burst_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    rd_turn_d   = rd_turn_q;
    unique case (state_q)
      IDLE: begin
        // A pending read turn beats new writes so the consumer is not starved.
        if (rd_turn_q && bus.rd_req && !bus.fifo_empty) begin
          state_d   = READ;
          rd_turn_d = 1'b0;
        end else if ((|bus.req) && !bus.fifo_full) begin
          state_d  = WRITE;
          gnt_id_d = rr_next;
        end else if (bus.rd_req && !bus.fifo_empty) begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (push) burst_cnt_d = burst_cnt_q + 4'd1;
        if (wr_exit) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
          rd_turn_d   = 1'b1;
        end
      end
      READ: begin
        if (rd_exit) begin
          state_d    = IDLE;
          slot_cnt_d = '0;
        end else begin
          slot_cnt_d = slot_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_c = '0;
    if (push) ack_c[gnt_id_q] = 1'b1;
  end

  // The FIFO pops on any edge without a write, so pop_vld tracks w_en=0 && !empty.
  assign pop_vld_d        = !push && !bus.fifo_empty;
  assign bus.ack          = ack_c;
  assign bus.fifo_w_en    = push;
  assign bus.fifo_data_in = bus.din[int'(gnt_id_q) * DW +: DW];
  assign bus.pop_vld      = pop_vld_q;
  assign bus.gnt_id       = gnt_id_q;
endmodule

// File: tb/tb_fifo_wr_sched.sv
// Bench for fifo_wr_sched: producer queues, a behavioural sync FIFO and
// scoreboards of expected acks and popped words.
module tb_fifo_wr_sched;
  localparam int N_REQ     = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int RD_SLOTS  = 2;
  localparam int GW        = $clog2(N_REQ);
  localparam int DEPTH     = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_sched_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  fifo_wr_sched #(.N_REQ(N_REQ), .DW(DW), .MAX_BURST(MAX_BURST), .RD_SLOTS(RD_SLOTS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DW-1:0]    pq[N_REQ][$];
  logic [DW-1:0]    fifo_q[$];
  logic [GW+DW-1:0] exp_ack_q[$];
  logic [DW-1:0]    exp_pop_q[$];

  int n_vec  = 0;
  int n_fail = 0;
  int n_push = 0;

  logic [N_REQ-1:0] obs_ack;
  logic             obs_w_en, obs_pop_vld, obs_full, obs_empty;
  logic [DW-1:0]    obs_data, obs_pop_word;
  logic [GW-1:0]    obs_gnt;
  logic             pend_pop = 1'b0;
  logic             exp_pop_vld;
  logic [DW-1:0]    pop_word = '0;

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req[i]          = (pq[i].size() > 0);
      bus.din[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
    bus.fifo_full  = (fifo_q.size() >= DEPTH);
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  // One clock: sample on the falling edge, apply the FIFO/producer effects of the rising edge.
  task automatic tick();
    @(negedge clk);
    obs_ack      = bus.ack;
    obs_w_en     = bus.fifo_w_en;
    obs_data     = bus.fifo_data_in;
    obs_pop_vld  = bus.pop_vld;
    obs_gnt      = bus.gnt_id;
    obs_full     = bus.fifo_full;
    obs_empty    = bus.fifo_empty;
    obs_pop_word = pop_word;
    exp_pop_vld  = pend_pop;
    @(posedge clk);
    pend_pop = 1'b0;
    if (obs_w_en && !obs_full) begin
      fifo_q.push_back(obs_data);
      n_push++;
    end else if (!obs_w_en && !obs_empty) begin
      pop_word = fifo_q.pop_front();
      pend_pop = !rst;
    end
    for (int i = 0; i < N_REQ; i++)
      if (obs_ack[i] && pq[i].size() > 0) pq[i].delete(0);
    #1 drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N_REQ; i++) pq[i].delete();
    fifo_q.delete();
    exp_ack_q.delete();
    exp_pop_q.delete();
    pend_pop   = 1'b0;
    bus.rd_req = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N_REQ; i++) pq[i].push_back(DW'(8'h10 + i));
    bus.rd_req = 1'b0;
    drive();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.ack, bus.fifo_w_en, bus.pop_vld} !== '0 || bus.gnt_id !== GW'(N_REQ-1)) begin
      n_fail++;
      $display("FAIL reset_async: ack=%b w_en=%b pop_vld=%b gnt=%0d, want 0/0/0/%0d",
               bus.ack, bus.fifo_w_en, bus.pop_vld, bus.gnt_id, N_REQ-1);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({bus.ack, bus.fifo_w_en, bus.pop_vld} !== '0 || bus.gnt_id !== GW'(N_REQ-1)) begin
      n_fail++;
      $display("FAIL reset_held: ack=%b w_en=%b pop_vld=%b gnt=%0d", bus.ack, bus.fifo_w_en,
               bus.pop_vld, bus.gnt_id);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.ack, bus.fifo_w_en, bus.pop_vld} !== '0 || bus.gnt_id !== GW'(N_REQ-1)) begin
      n_fail++;
      $display("FAIL reset_release: ack=%b w_en=%b pop_vld=%b gnt=%0d", bus.ack, bus.fifo_w_en,
               bus.pop_vld, bus.gnt_id);
    end
  endtask

  task automatic test_single_port();
    logic [GW+DW-1:0] e;
    int acks, first, last;
    logic [DW-1:0] words[3] = '{8'hfa, 8'hcc, 8'h1c};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pq[0].push_back(words[k]);
      exp_ack_q.push_back({GW'(0), words[k]});
    end
    drive();
    acks = 0; first = -1; last = -1;
    for (int c = 0; c < 20 && acks < 3; c++) begin
      tick();
      if (obs_ack != '0) begin
        e = (exp_ack_q.size() > 0) ? exp_ack_q.pop_front() : '1;
        n_vec++;
        if (obs_ack !== (N_REQ'(1) << e[GW+DW-1:DW]) || obs_data !== e[DW-1:0] || !obs_w_en) begin
          n_fail++;
          $display("FAIL single_ack: ack=%b data=%h w_en=%b, want port %0d data %h",
                   obs_ack, obs_data, obs_w_en, e[GW+DW-1:DW], e[DW-1:0]);
        end
        if (first < 0) first = c;
        last = c;
        acks++;
      end
    end
    n_vec++;
    if (acks != 3 || last - first != 2) begin
      n_fail++;
      $display("FAIL single_consecutive: acks=%0d span=%0d, want 3 acks span 2", acks, last - first);
    end
    n_vec++;
    if (fifo_q.size() != 3 || {fifo_q[0], fifo_q[1], fifo_q[2]} !== 24'hfacc1c) begin
      n_fail++;
      $display("FAIL single_fifo: size=%0d, want fa,cc,1c", fifo_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [GW+DW-1:0] e;
    int acks, zeros;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      pq[0].push_back(DW'(8'h00 + k));
      pq[2].push_back(DW'(8'h20 + k));
    end
    for (int k = 0; k < 4; k++) exp_ack_q.push_back({GW'(0), DW'(8'h00 + k)});
    for (int k = 0; k < 4; k++) exp_ack_q.push_back({GW'(2), DW'(8'h20 + k)});
    for (int k = 4; k < 8; k++) exp_ack_q.push_back({GW'(0), DW'(8'h00 + k)});
    drive();
    acks = 0; zeros = 0;
    for (int c = 0; c < 80 && acks < 12; c++) begin
      tick();
      if (obs_w_en) begin
        if (acks > 0) begin
          n_vec++;
          if (zeros != ((acks % MAX_BURST == 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL rr_gap: before push %0d idle=%0d", acks, zeros);
          end
        end
        e = (exp_ack_q.size() > 0) ? exp_ack_q.pop_front() : '1;
        n_vec++;
        if (obs_ack !== (N_REQ'(1) << e[GW+DW-1:DW]) || obs_data !== e[DW-1:0] ||
            obs_gnt !== e[GW+DW-1:DW]) begin
          n_fail++;
          $display("FAIL rr_ack: ack=%b data=%h gnt=%0d, want port %0d data %h",
                   obs_ack, obs_data, obs_gnt, e[GW+DW-1:DW], e[DW-1:0]);
        end
        zeros = 0;
        acks++;
      end else begin
        zeros++;
      end
    end
    n_vec++;
    if (acks != 12) begin
      n_fail++;
      $display("FAIL rr_count: got %0d pushes, want 12", acks);
    end
  endtask

  task automatic test_full();
    logic [GW+DW-1:0] e;
    int acks, full_cycles;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      pq[1].push_back(DW'(8'h40 + k));
      exp_ack_q.push_back({GW'(1), DW'(8'h40 + k)});
    end
    drive();
    acks = 0; full_cycles = 0;
    for (int c = 0; c < 300 && acks < 30; c++) begin
      tick();
      if (obs_full) begin
        full_cycles++;
        n_vec++;
        if (obs_ack !== '0 || obs_w_en !== 1'b0 || obs_gnt !== GW'(1)) begin
          n_fail++;
          $display("FAIL full_block: ack=%b w_en=%b gnt=%0d, want 0/0/1", obs_ack, obs_w_en, obs_gnt);
        end
      end
      if (obs_w_en) begin
        e = (exp_ack_q.size() > 0) ? exp_ack_q.pop_front() : '1;
        n_vec++;
        if (obs_ack !== (N_REQ'(1) << e[GW+DW-1:DW]) || obs_data !== e[DW-1:0]) begin
          n_fail++;
          $display("FAIL full_order: ack=%b data=%h, want port %0d data %h",
                   obs_ack, obs_data, e[GW+DW-1:DW], e[DW-1:0]);
        end
        acks++;
      end
    end
    n_vec++;
    if (acks != 30 || exp_ack_q.size() != 0 || full_cycles == 0) begin
      n_fail++;
      $display("FAIL full_summary: pushes=%0d left=%0d full_cycles=%0d, want 30/0/>0",
               acks, exp_ack_q.size(), full_cycles);
    end
  endtask

  task automatic test_read_window();
    logic [GW+DW-1:0] e;
    logic [DW-1:0] pw;
    int acks, pops, zeros;
    do_reset();
    bus.rd_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      pq[3].push_back(DW'(8'h80 + k));
      exp_ack_q.push_back({GW'(3), DW'(8'h80 + k)});
      exp_pop_q.push_back(DW'(8'h80 + k));
    end
    drive();
    acks = 0; pops = 0; zeros = 0;
    for (int c = 0; c < 200 && (acks < 12 || pops < 12); c++) begin
      tick();
      n_vec++;
      if (obs_pop_vld !== exp_pop_vld) begin
        n_fail++;
        $display("FAIL rw_pop_vld: cycle %0d got %b want %b", c, obs_pop_vld, exp_pop_vld);
      end
      if (obs_pop_vld && exp_pop_vld) begin
        pw = (exp_pop_q.size() > 0) ? exp_pop_q.pop_front() : '1;
        n_vec++;
        if (obs_pop_word !== pw) begin
          n_fail++;
          $display("FAIL rw_pop_data: got %h want %h", obs_pop_word, pw);
        end
        pops++;
      end
      if (obs_w_en) begin
        // Between bursts: burst-exit IDLE, RD_SLOTS read cycles, re-grant IDLE.
        if (acks > 0 && acks % MAX_BURST == 0) begin
          n_vec++;
          if (zeros != RD_SLOTS + 2) begin
            n_fail++;
            $display("FAIL rw_gap: before push %0d w_en=0 for %0d, want %0d", acks, zeros, RD_SLOTS + 2);
          end
        end
        e = (exp_ack_q.size() > 0) ? exp_ack_q.pop_front() : '1;
        n_vec++;
        if (obs_ack !== (N_REQ'(1) << e[GW+DW-1:DW]) || obs_data !== e[DW-1:0]) begin
          n_fail++;
          $display("FAIL rw_ack: ack=%b data=%h, want port %0d data %h",
                   obs_ack, obs_data, e[GW+DW-1:DW], e[DW-1:0]);
        end
        zeros = 0;
        acks++;
      end else begin
        zeros++;
      end
    end
    n_vec++;
    if (acks != 12 || pops != 12) begin
      n_fail++;
      $display("FAIL rw_count: pushes=%0d pops=%0d, want 12/12", acks, pops);
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [GW+DW-1:0] e;
    int acks, push_before;
    do_reset();
    for (int k = 0; k < 4; k++) pq[0].push_back(DW'(8'hc0 + k));
    for (int k = 0; k < 3; k++) exp_ack_q.push_back({GW'(0), DW'(8'hc0 + k)});
    drive();
    acks = 0;
    for (int c = 0; c < 10 && acks < 2; c++) begin
      tick();
      if (obs_ack != '0) begin
        e = exp_ack_q.pop_front();
        acks++;
      end
    end
    n_vec++;
    if (bus.ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL rmb_pre: ack before reset=%b want 0001", bus.ack);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.ack !== '0 || bus.fifo_w_en !== 1'b0 || bus.gnt_id !== GW'(N_REQ-1)) begin
      n_fail++;
      $display("FAIL rmb_clear: ack=%b w_en=%b gnt=%0d, want 0/0/%0d", bus.ack, bus.fifo_w_en,
               bus.gnt_id, N_REQ-1);
    end
    for (int i = 1; i < N_REQ; i++) pq[i].push_back(DW'(8'hd0 + i));
    drive();
    push_before = n_push;
    repeat (2) tick();
    n_vec++;
    if (n_push != push_before || obs_w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rmb_spurious: pushes during reset=%0d w_en=%b, want 0/0", n_push - push_before, obs_w_en);
    end
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 10 && acks < 1; c++) begin
      tick();
      if (obs_ack != '0) begin
        e = (exp_ack_q.size() > 0) ? exp_ack_q.pop_front() : '1;
        n_vec++;
        if (obs_ack !== 4'b0001 || obs_data !== e[DW-1:0]) begin
          n_fail++;
          $display("FAIL rmb_first_grant: ack=%b data=%h, want 0001 data %h", obs_ack, obs_data, e[DW-1:0]);
        end
        acks++;
      end
    end
    n_vec++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL rmb_timeout: no grant after reset release");
    end
  endtask

  initial begin
    bus.rd_req = 1'b0;
    drive();
    test_reset();
    test_single_port();
    test_round_robin();
    test_full();
    test_read_window();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
